// File: rtl/rs_station_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rs_station_pkg : shared sizing defaults and ALU opcode encodings for the   |
// |                  reservation station and its external rs_chooser.          |
// | Revision       : 1.0 - initial release                                     |
// +----------------------------------------------------------------------------+

`ifndef RS_SIZE
`define RS_SIZE 8
`endif
`ifndef RS_SIZE_WIDTH
`define RS_SIZE_WIDTH 3
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 3
`endif

package rs_station_pkg;

    localparam int OP_WIDTH   = 6;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_ADD  = 6'd0,
        OP_SUB  = 6'd1,
        OP_AND  = 6'd2,
        OP_OR   = 6'd3,
        OP_XOR  = 6'd4,
        OP_SLL  = 6'd5,
        OP_SRL  = 6'd6,
        OP_SRA  = 6'd7,
        OP_SLT  = 6'd8,
        OP_SLTU = 6'd9
    } alu_op_e;

endpackage

`default_nettype wire

// File: rtl/rs_station.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rs_station : ALU reservation station; holds issued ops, snoops ALU/LSB CDBs |
// |              and dispatches the chooser-selected ready entry to the ALU.   |
// | Option     : define RS_CDB_BYPASS_EN to capture same-cycle CDB on issue.   |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+

`ifndef RS_SIZE
`define RS_SIZE 8
`endif
`ifndef RS_SIZE_WIDTH
`define RS_SIZE_WIDTH 3
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 3
`endif

module rs_station
    import rs_station_pkg::*;
#(
    parameter int RS_SIZE       = `RS_SIZE,
    parameter int RS_SIZE_WIDTH = `RS_SIZE_WIDTH,
    parameter int ROB_WIDTH     = `ROB_SIZE_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     clear,
    input  logic                     issue_valid,
    input  logic [OP_WIDTH-1:0]      issue_op,
    input  logic [DATA_WIDTH-1:0]    issue_vj,
    input  logic [DATA_WIDTH-1:0]    issue_vk,
    input  logic [DATA_WIDTH-1:0]    issue_imm,
    input  logic [DATA_WIDTH-1:0]    issue_pc,
    input  logic                     issue_qj_valid,
    input  logic                     issue_qk_valid,
    input  logic [ROB_WIDTH-1:0]     issue_qj,
    input  logic [ROB_WIDTH-1:0]     issue_qk,
    input  logic [ROB_WIDTH-1:0]     issue_rob_id,
    output logic                     full,
    output logic [RS_SIZE-1:0]       busy,
    output logic [RS_SIZE-1:0]       ready,
    input  logic [RS_SIZE_WIDTH-1:0] free_rs_line,
    input  logic                     has_exe_rs_line,
    input  logic [RS_SIZE_WIDTH-1:0] exe_rs_line,
    input  logic                     alu_cdb_valid,
    input  logic [ROB_WIDTH-1:0]     alu_cdb_rob_id,
    input  logic [DATA_WIDTH-1:0]    alu_cdb_value,
    input  logic                     lsb_cdb_valid,
    input  logic [ROB_WIDTH-1:0]     lsb_cdb_rob_id,
    input  logic [DATA_WIDTH-1:0]    lsb_cdb_value,
    output logic                     alu_valid,
    output logic [OP_WIDTH-1:0]      alu_op,
    output logic [DATA_WIDTH-1:0]    alu_v1,
    output logic [DATA_WIDTH-1:0]    alu_v2,
    output logic [DATA_WIDTH-1:0]    alu_imm,
    output logic [DATA_WIDTH-1:0]    alu_pc,
    output logic [ROB_WIDTH-1:0]     alu_rob_id
);

    logic [RS_SIZE-1:0]    r_busy;
    logic [RS_SIZE-1:0]    r_qj_valid;
    logic [RS_SIZE-1:0]    r_qk_valid;
    logic [OP_WIDTH-1:0]   r_op     [RS_SIZE];
    logic [DATA_WIDTH-1:0] r_vj     [RS_SIZE];
    logic [DATA_WIDTH-1:0] r_vk     [RS_SIZE];
    logic [DATA_WIDTH-1:0] r_imm    [RS_SIZE];
    logic [DATA_WIDTH-1:0] r_pc     [RS_SIZE];
    logic [ROB_WIDTH-1:0]  r_qj     [RS_SIZE];
    logic [ROB_WIDTH-1:0]  r_qk     [RS_SIZE];
    logic [ROB_WIDTH-1:0]  r_rob_id [RS_SIZE];

    logic                  w_iss_qj_valid;
    logic                  w_iss_qk_valid;
    logic [DATA_WIDTH-1:0] w_iss_vj;
    logic [DATA_WIDTH-1:0] w_iss_vk;

    assign busy  = r_busy;
    assign ready = r_busy & ~r_qj_valid & ~r_qk_valid;
    assign full  = &r_busy;

`ifdef RS_CDB_BYPASS_EN
    // Resolve issued operands against this cycle's broadcasts; ALU CDB has priority.
    always_comb begin
        w_iss_qj_valid = issue_qj_valid;
        w_iss_vj       = issue_vj;
        w_iss_qk_valid = issue_qk_valid;
        w_iss_vk       = issue_vk;
        if (issue_qj_valid) begin
            if (alu_cdb_valid && alu_cdb_rob_id == issue_qj) begin
                w_iss_qj_valid = 1'b0;
                w_iss_vj       = alu_cdb_value;
            end else if (lsb_cdb_valid && lsb_cdb_rob_id == issue_qj) begin
                w_iss_qj_valid = 1'b0;
                w_iss_vj       = lsb_cdb_value;
            end
        end
        if (issue_qk_valid) begin
            if (alu_cdb_valid && alu_cdb_rob_id == issue_qk) begin
                w_iss_qk_valid = 1'b0;
                w_iss_vk       = alu_cdb_value;
            end else if (lsb_cdb_valid && lsb_cdb_rob_id == issue_qk) begin
                w_iss_qk_valid = 1'b0;
                w_iss_vk       = lsb_cdb_value;
            end
        end
    end
`else
    assign w_iss_qj_valid = issue_qj_valid;
    assign w_iss_qk_valid = issue_qk_valid;
    assign w_iss_vj       = issue_vj;
    assign w_iss_vk       = issue_vk;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy     <= '0;
            r_qj_valid <= '0;
            r_qk_valid <= '0;
            alu_valid  <= 1'b0;
            alu_op     <= '0;
            alu_v1     <= '0;
            alu_v2     <= '0;
            alu_imm    <= '0;
            alu_pc     <= '0;
            alu_rob_id <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                r_op[i]     <= '0;
                r_vj[i]     <= '0;
                r_vk[i]     <= '0;
                r_imm[i]    <= '0;
                r_pc[i]     <= '0;
                r_qj[i]     <= '0;
                r_qk[i]     <= '0;
                r_rob_id[i] <= '0;
            end
        end else if (rdy) begin
            alu_valid <= 1'b0;
            if (clear) begin
                r_busy     <= '0;
                r_qj_valid <= '0;
                r_qk_valid <= '0;
            end else begin
                // CDB snoop: only pending operands of live entries listen.
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (r_busy[i] && r_qj_valid[i]) begin
                        if (alu_cdb_valid && alu_cdb_rob_id == r_qj[i]) begin
                            r_vj[i]       <= alu_cdb_value;
                            r_qj_valid[i] <= 1'b0;
                        end else if (lsb_cdb_valid && lsb_cdb_rob_id == r_qj[i]) begin
                            r_vj[i]       <= lsb_cdb_value;
                            r_qj_valid[i] <= 1'b0;
                        end
                    end
                    if (r_busy[i] && r_qk_valid[i]) begin
                        if (alu_cdb_valid && alu_cdb_rob_id == r_qk[i]) begin
                            r_vk[i]       <= alu_cdb_value;
                            r_qk_valid[i] <= 1'b0;
                        end else if (lsb_cdb_valid && lsb_cdb_rob_id == r_qk[i]) begin
                            r_vk[i]       <= lsb_cdb_value;
                            r_qk_valid[i] <= 1'b0;
                        end
                    end
                end

                if (has_exe_rs_line) begin
                    alu_valid           <= 1'b1;
                    alu_op              <= r_op[exe_rs_line];
                    alu_v1              <= r_vj[exe_rs_line];
                    alu_v2              <= r_vk[exe_rs_line];
                    alu_imm             <= r_imm[exe_rs_line];
                    alu_pc              <= r_pc[exe_rs_line];
                    alu_rob_id          <= r_rob_id[exe_rs_line];
                    r_busy[exe_rs_line] <= 1'b0;
                end

                // The chooser never picks a busy free line, so this cannot collide with dispatch.
                if (issue_valid && !full) begin
                    r_busy[free_rs_line]     <= 1'b1;
                    r_op[free_rs_line]       <= issue_op;
                    r_vj[free_rs_line]       <= w_iss_vj;
                    r_vk[free_rs_line]       <= w_iss_vk;
                    r_imm[free_rs_line]      <= issue_imm;
                    r_pc[free_rs_line]       <= issue_pc;
                    r_qj_valid[free_rs_line] <= w_iss_qj_valid;
                    r_qk_valid[free_rs_line] <= w_iss_qk_valid;
                    r_qj[free_rs_line]       <= issue_qj;
                    r_qk[free_rs_line]       <= issue_qk;
                    r_rob_id[free_rs_line]   <= issue_rob_id;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rs_station.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rs_station : directed, table-driven self-checking bench for rs_station. |
// | Revision      : 1.0 - initial release                                      |
// +----------------------------------------------------------------------------+

module tb_rs_station;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        clear;
    logic        issue_valid;
    logic [5:0]  issue_op;
    logic [31:0] issue_vj, issue_vk, issue_imm, issue_pc;
    logic        issue_qj_valid, issue_qk_valid;
    logic [2:0]  issue_qj, issue_qk, issue_rob_id;
    logic        full;
    logic [7:0]  busy, ready;
    logic [2:0]  free_rs_line;
    logic        has_exe_rs_line;
    logic [2:0]  exe_rs_line;
    logic        alu_cdb_valid, lsb_cdb_valid;
    logic [2:0]  alu_cdb_rob_id, lsb_cdb_rob_id;
    logic [31:0] alu_cdb_value, lsb_cdb_value;
    logic        alu_valid;
    logic [5:0]  alu_op;
    logic [31:0] alu_v1, alu_v2, alu_imm, alu_pc;
    logic [2:0]  alu_rob_id;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rs_station dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .clear           (clear),
        .issue_valid     (issue_valid),
        .issue_op        (issue_op),
        .issue_vj        (issue_vj),
        .issue_vk        (issue_vk),
        .issue_imm       (issue_imm),
        .issue_pc        (issue_pc),
        .issue_qj_valid  (issue_qj_valid),
        .issue_qk_valid  (issue_qk_valid),
        .issue_qj        (issue_qj),
        .issue_qk        (issue_qk),
        .issue_rob_id    (issue_rob_id),
        .full            (full),
        .busy            (busy),
        .ready           (ready),
        .free_rs_line    (free_rs_line),
        .has_exe_rs_line (has_exe_rs_line),
        .exe_rs_line     (exe_rs_line),
        .alu_cdb_valid   (alu_cdb_valid),
        .alu_cdb_rob_id  (alu_cdb_rob_id),
        .alu_cdb_value   (alu_cdb_value),
        .lsb_cdb_valid   (lsb_cdb_valid),
        .lsb_cdb_rob_id  (lsb_cdb_rob_id),
        .lsb_cdb_value   (lsb_cdb_value),
        .alu_valid       (alu_valid),
        .alu_op          (alu_op),
        .alu_v1          (alu_v1),
        .alu_v2          (alu_v2),
        .alu_imm         (alu_imm),
        .alu_pc          (alu_pc),
        .alu_rob_id      (alu_rob_id)
    );

    typedef struct {
        logic        iv;
        logic [2:0]  fl;
        logic [31:0] vj, vk;
        logic        qjv;
        logic [2:0]  qj;
        logic        qkv;
        logic [2:0]  qk;
        logic        ex;
        logic [2:0]  el;
        logic        acv;
        logic [2:0]  act;
        logic [31:0] acval;
        logic        lcv;
        logic [2:0]  lct;
        logic [31:0] lcval;
        logic [7:0]  e_busy, e_ready;
        logic        e_av;
        logic [31:0] e_v1, e_v2;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mk(
        input logic iv, input logic [2:0] fl, input logic [31:0] vj, input logic [31:0] vk,
        input logic qjv, input logic [2:0] qj, input logic qkv, input logic [2:0] qk,
        input logic ex, input logic [2:0] el,
        input logic acv, input logic [2:0] act, input logic [31:0] acval,
        input logic lcv, input logic [2:0] lct, input logic [31:0] lcval,
        input logic [7:0] e_busy, input logic [7:0] e_ready,
        input logic e_av, input logic [31:0] e_v1, input logic [31:0] e_v2);
        vec_t v;
        v.iv = iv; v.fl = fl; v.vj = vj; v.vk = vk;
        v.qjv = qjv; v.qj = qj; v.qkv = qkv; v.qk = qk;
        v.ex = ex; v.el = el;
        v.acv = acv; v.act = act; v.acval = acval;
        v.lcv = lcv; v.lct = lct; v.lcval = lcval;
        v.e_busy = e_busy; v.e_ready = e_ready;
        v.e_av = e_av; v.e_v1 = e_v1; v.e_v2 = e_v2;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clear           = 1'b0;
        issue_valid     = 1'b0;
        issue_op        = '0;
        issue_vj        = '0;
        issue_vk        = '0;
        issue_imm       = '0;
        issue_pc        = '0;
        issue_qj_valid  = 1'b0;
        issue_qk_valid  = 1'b0;
        issue_qj        = '0;
        issue_qk        = '0;
        issue_rob_id    = '0;
        free_rs_line    = '0;
        has_exe_rs_line = 1'b0;
        exe_rs_line     = '0;
        alu_cdb_valid   = 1'b0;
        alu_cdb_rob_id  = '0;
        alu_cdb_value   = '0;
        lsb_cdb_valid   = 1'b0;
        lsb_cdb_rob_id  = '0;
        lsb_cdb_value   = '0;
    endtask

    // Side fields are derived from the line so dispatch can verify them too.
    task automatic issue(input logic [2:0] line, input logic [31:0] vj, input logic [31:0] vk,
                         input logic qjv, input logic [2:0] qj, input logic qkv, input logic [2:0] qk);
        issue_valid    = 1'b1;
        free_rs_line   = line;
        issue_op       = 6'h10 + {3'b000, line};
        issue_vj       = vj;
        issue_vk       = vk;
        issue_imm      = 32'h1000 + {29'd0, line};
        issue_pc       = 32'h2000 + {27'd0, line, 2'b00};
        issue_rob_id   = line + 3'd1;
        issue_qj_valid = qjv;
        issue_qj       = qj;
        issue_qk_valid = qkv;
        issue_qk       = qk;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] el;
        rst = 1'b0;
        rdy = 1'b1;
        idle();

        vecs[0]  = mk(1,0,5,7,          0,0,0,0, 0,0, 0,0,0,     0,0,0,     8'h01,8'h01, 0,0,0);
        vecs[1]  = mk(0,0,0,0,          0,0,0,0, 1,0, 0,0,0,     0,0,0,     8'h00,8'h00, 1,5,7);
        vecs[2]  = mk(0,0,0,0,          0,0,0,0, 0,0, 0,0,0,     0,0,0,     8'h00,8'h00, 0,0,0);
        vecs[3]  = mk(1,1,0,2,          1,3,0,0, 0,0, 0,0,0,     0,0,0,     8'h02,8'h00, 0,0,0);
        vecs[4]  = mk(0,0,0,0,          0,0,0,0, 0,0, 1,3,32'h10,0,0,0,     8'h02,8'h02, 0,0,0);
        vecs[5]  = mk(0,0,0,0,          0,0,0,0, 1,1, 0,0,0,     0,0,0,     8'h00,8'h00, 1,32'h10,2);
        vecs[6]  = mk(1,2,4,0,          0,0,1,2, 0,0, 0,0,0,     0,0,0,     8'h04,8'h00, 0,0,0);
        vecs[7]  = mk(0,0,0,0,          0,0,0,0, 0,0, 1,2,1,     1,2,9,     8'h04,8'h04, 0,0,0);
        vecs[8]  = mk(0,0,0,0,          0,0,0,0, 1,2, 0,0,0,     0,0,0,     8'h00,8'h00, 1,4,1);
        vecs[9]  = mk(1,3,8,9,          0,0,0,0, 0,0, 0,0,0,     0,0,0,     8'h08,8'h08, 0,0,0);
        vecs[10] = mk(1,4,1,2,          0,0,0,0, 1,3, 0,0,0,     0,0,0,     8'h10,8'h10, 1,8,9);
        vecs[11] = mk(0,0,0,0,          0,0,0,0, 1,4, 0,0,0,     0,0,0,     8'h00,8'h00, 1,1,2);
        vecs[12] = mk(1,5,0,3,          1,6,0,0, 0,0, 0,0,0,     0,0,0,     8'h20,8'h00, 0,0,0);
        vecs[13] = mk(0,0,0,0,          0,0,0,0, 0,0, 1,5,32'h55,0,0,0,     8'h20,8'h00, 0,0,0);
        vecs[14] = mk(0,0,0,0,          0,0,0,0, 0,0, 0,0,0,     1,6,32'h66,8'h20,8'h20, 0,0,0);
        vecs[15] = mk(0,0,0,0,          0,0,0,0, 1,5, 0,0,0,     0,0,0,     8'h00,8'h00, 1,32'h66,3);

        // Asynchronous reset state, before any clock edge.
        #3;
        check("reset busy", {24'd0, busy}, 32'h0);
        check("reset ready", {24'd0, ready}, 32'h0);
        check("reset full", {31'd0, full}, 32'h0);
        check("reset alu_valid", {31'd0, alu_valid}, 32'h0);
        check("reset alu_v1", alu_v1, 32'h0);
        tick();
        tick();
        rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            idle();
            if (vecs[i].iv)
                issue(vecs[i].fl, vecs[i].vj, vecs[i].vk, vecs[i].qjv, vecs[i].qj, vecs[i].qkv, vecs[i].qk);
            has_exe_rs_line = vecs[i].ex;
            exe_rs_line     = vecs[i].el;
            alu_cdb_valid   = vecs[i].acv;
            alu_cdb_rob_id  = vecs[i].act;
            alu_cdb_value   = vecs[i].acval;
            lsb_cdb_valid   = vecs[i].lcv;
            lsb_cdb_rob_id  = vecs[i].lct;
            lsb_cdb_value   = vecs[i].lcval;
            tick();
            check($sformatf("vec%0d busy", i), {24'd0, busy}, {24'd0, vecs[i].e_busy});
            check($sformatf("vec%0d ready", i), {24'd0, ready}, {24'd0, vecs[i].e_ready});
            check($sformatf("vec%0d alu_valid", i), {31'd0, alu_valid}, {31'd0, vecs[i].e_av});
            if (vecs[i].e_av) begin
                el = vecs[i].el;
                check($sformatf("vec%0d alu_v1", i), alu_v1, vecs[i].e_v1);
                check($sformatf("vec%0d alu_v2", i), alu_v2, vecs[i].e_v2);
                check($sformatf("vec%0d alu_op", i), {26'd0, alu_op}, 32'h10 + {29'd0, el});
                check($sformatf("vec%0d alu_imm", i), alu_imm, 32'h1000 + {29'd0, el});
                check($sformatf("vec%0d alu_pc", i), alu_pc, 32'h2000 + {27'd0, el, 2'b00});
                check($sformatf("vec%0d alu_rob_id", i), {29'd0, alu_rob_id}, {29'd0, el + 3'd1});
            end
        end

        // rdy low freezes everything, including alu_valid.
        idle();
        issue(3'd0, 32'h11, 32'h22, 1'b0, 3'd0, 1'b0, 3'd0);
        tick();
        check("freeze setup busy", {24'd0, busy}, 32'h01);
        idle();
        rdy = 1'b0;
        issue(3'd1, 32'h33, 32'h44, 1'b0, 3'd0, 1'b0, 3'd0);
        has_exe_rs_line = 1'b1;
        exe_rs_line     = 3'd0;
        tick();
        check("frozen busy", {24'd0, busy}, 32'h01);
        check("frozen alu_valid low", {31'd0, alu_valid}, 32'h0);
        idle();
        rdy = 1'b1;
        has_exe_rs_line = 1'b1;
        exe_rs_line     = 3'd0;
        tick();
        check("thaw dispatch alu_valid", {31'd0, alu_valid}, 32'h1);
        check("thaw dispatch alu_v1", alu_v1, 32'h11);
        idle();
        rdy = 1'b0;
        tick();
        check("frozen alu_valid high", {31'd0, alu_valid}, 32'h1);
        rdy = 1'b1;
        tick();
        check("alu_valid single pulse", {31'd0, alu_valid}, 32'h0);

        // Fill all entries, then an issue while full must be ignored.
        for (int i = 0; i < 8; i++) begin
            idle();
            issue(3'(i), 32'h100 + 32'(i), 32'h200 + 32'(i), 1'b0, 3'd0, 1'b0, 3'd0);
            tick();
        end
        idle();
        check("full busy", {24'd0, busy}, 32'hFF);
        check("full flag", {31'd0, full}, 32'h1);
        issue(3'd0, 32'hDEAD, 32'hBEEF, 1'b1, 3'd7, 1'b0, 3'd0);
        tick();
        check("full ignore ready", {24'd0, ready}, 32'hFF);
        idle();
        has_exe_rs_line = 1'b1;
        exe_rs_line     = 3'd0;
        tick();
        check("full dispatch alu_v1", alu_v1, 32'h100);
        check("full dispatch alu_v2", alu_v2, 32'h200);
        check("full deasserted", {31'd0, full}, 32'h0);
        check("full dispatch busy", {24'd0, busy}, 32'hFE);

        // clear overrides both issue and dispatch.
        idle();
        clear = 1'b1;
        tick();
        check("clear empties", {24'd0, busy}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            idle();
            issue(3'(i), 32'h300 + 32'(i), 32'h0, 1'b0, 3'd0, 1'b0, 3'd0);
            tick();
        end
        check("pre-clear busy", {24'd0, busy}, 32'h0F);
        idle();
        issue(3'd4, 32'h1, 32'h2, 1'b0, 3'd0, 1'b0, 3'd0);
        has_exe_rs_line = 1'b1;
        exe_rs_line     = 3'd1;
        clear           = 1'b1;
        tick();
        check("clear busy", {24'd0, busy}, 32'h0);
        check("clear alu_valid", {31'd0, alu_valid}, 32'h0);

        // Reset while a dispatch is in flight drops it asynchronously.
        idle();
        issue(3'd2, 32'h77, 32'h88, 1'b0, 3'd0, 1'b0, 3'd0);
        tick();
        idle();
        has_exe_rs_line = 1'b1;
        exe_rs_line     = 3'd2;
        tick();
        check("pre-reset alu_valid", {31'd0, alu_valid}, 32'h1);
        idle();
        #1;
        rst = 1'b0;
        #1;
        check("async reset alu_valid", {31'd0, alu_valid}, 32'h0);
        check("async reset alu_v1", alu_v1, 32'h0);
        check("async reset alu_rob_id", {29'd0, alu_rob_id}, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        check("post-reset busy", {24'd0, busy}, 32'h0);

`ifdef RS_CDB_BYPASS_EN
        idle();
        issue(3'd0, 32'h0, 32'h5, 1'b1, 3'd4, 1'b0, 3'd0);
        lsb_cdb_valid  = 1'b1;
        lsb_cdb_rob_id = 3'd4;
        lsb_cdb_value  = 32'hAB;
        tick();
        check("bypass ready", {24'd0, ready}, 32'h01);
        idle();
        has_exe_rs_line = 1'b1;
        exe_rs_line     = 3'd0;
        tick();
        check("bypass alu_v1", alu_v1, 32'hAB);
`endif

        idle();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
